// File: rtl/hilo_muldiv_unit.sv
// Iterative mult/multu/div/divu engine owning HI/LO, plus mthi/mtlo moves.
// Mult/div results land 34 edges after start; start is ignored while busy.
module hilo_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, PREP, ITER, FIX} state_t;

  state_t               state_q, state_d;
  logic [5:0]           cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic [1:0]           op_q, op_d;        // {is_div, is_unsigned}
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH:0]       rem_q, rem_d;
  logic                 neg_q, neg_d;
  logic                 rneg_q, rneg_d;

  logic                 is_signed;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH+1:0]     div_shift, div_trial;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     quo, rmd;

  assign is_signed = ~op_q[0];
  assign mag_a     = (is_signed && a_q[WIDTH-1]) ? -a_q : a_q;
  assign mag_b     = (is_signed && b_q[WIDTH-1]) ? -b_q : b_q;
  assign mul_sum   = acc_q[0] ? ({1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, b_q})
                              : {1'b0, acc_q[2*WIDTH-1:WIDTH]};
  // Partial remainder never exceeds the divisor, so the 34-bit trial cannot wrap.
  assign div_shift = {rem_q, acc_q[WIDTH-1]};
  assign div_trial = div_shift - {2'b00, b_q};
  assign prod      = neg_q ? -acc_q : acc_q;
  assign quo       = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rmd       = rneg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          case (op)
            3'b000, 3'b001, 3'b010, 3'b011: begin
              op_d    = op[1:0];
              a_d     = rs_val;
              b_d     = rt_val;
              busy_d  = 1'b1;
              state_d = PREP;
            end
            3'b100:  hi_d = rs_val;
            3'b101:  lo_d = rs_val;
            default: ;
          endcase
        end
      end
      PREP: begin
        // a_q keeps the raw dividend for the divide-by-zero result.
        b_d     = mag_b;
        acc_d   = {{WIDTH{1'b0}}, mag_a};
        rem_d   = '0;
        neg_d   = is_signed & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
        rneg_d  = is_signed & a_q[WIDTH-1];
        cnt_d   = '0;
        state_d = ITER;
      end
      ITER: begin
        if (op_q[1]) begin
          if (!div_trial[WIDTH+1]) begin
            rem_d = div_trial[WIDTH:0];
            acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d = div_shift[WIDTH:0];
            acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) state_d = FIX;
      end
      FIX: begin
        if (!op_q[1]) begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end else if (b_q == '0) begin
          hi_d = a_q;
          lo_d = '1;
        end else begin
          hi_d = rmd;
          lo_d = quo;
        end
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed bench for hilo_muldiv_unit: hand-computed HI/LO results, latency and busy handling.
module tb_hilo_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  int n_chk  = 0;
  int n_pass = 0;

  hilo_muldiv_unit #(.WIDTH(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .hi     (hi),
    .lo     (lo),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Called at a negedge with busy low; returns at the negedge where done is high.
  task automatic mul_div(input string tag, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                         input bit inject);
    int n;
    logic [31:0] hi0;
    hi0    = hi;
    start  = 1'b1;
    op     = o;
    rs_val = a;
    rt_val = b;
    @(negedge clk);
    start  = 1'b0;
    rs_val = ~a;
    rt_val = ~b;
    chk({tag, "_done_clr"}, done, 1'b0);
    n = 0;
    while (busy && n < 100) begin
      n++;
      if (inject && n == 5) begin
        start  = 1'b1;
        op     = 3'b100;
        rs_val = 32'hAAAA0000;
      end
      if (inject && n == 6) start = 1'b0;
      if (n == 20) chk({tag, "_hi_hold"}, hi, hi0);
      @(negedge clk);
    end
    chk({tag, "_busy_cycles"}, n, 34);
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_hi"}, hi, ehi);
    chk({tag, "_lo"}, lo, elo);
  endtask

  task automatic mv(input string tag, input logic [2:0] o, input logic [31:0] v);
    start  = 1'b1;
    op     = o;
    rs_val = v;
    @(negedge clk);
    start  = 1'b0;
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int pulses;
    rst    = 1'b1;
    start  = 1'b0;
    op     = 3'b000;
    rs_val = '0;
    rt_val = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);

    // Back-to-back: each op launches in the previous op's done cycle.
    mul_div("multu_max",  3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    mul_div("mult_neg",   3'b000, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
    mul_div("mult_min",   3'b000, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0);
    mul_div("div_neg",    3'b010, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    mul_div("div_negdvs", 3'b010, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0);
    mul_div("div_ovf",    3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
    mul_div("divu_zero",  3'b011, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF, 1'b0);
    mul_div("div_zero",   3'b010, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF, 1'b0);
    mul_div("div_zneg",   3'b010, 32'hFFFFFF9C, 32'h00000000, 32'hFFFFFF9C, 32'hFFFFFFFF, 1'b0);
    mul_div("divu_mthi",  3'b011, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 1'b1);
    @(negedge clk);
    chk("done_single", done, 1'b0);

    mv("mtlo", 3'b101, 32'h00000005);
    chk("mtlo_lo", lo, 32'h00000005);
    chk("mtlo_hi", hi, 32'h00000002);
    mv("op110", 3'b110, 32'h0000FFFF);
    chk("op110_hi", hi, 32'h00000002);
    chk("op110_lo", lo, 32'h00000005);

    mv("mthi_pre", 3'b100, 32'h12345678);
    mv("mtlo_pre", 3'b101, 32'h12345678);
    chk("pre_hi", hi, 32'h12345678);
    chk("pre_lo", lo, 32'h12345678);
    start  = 1'b1;
    op     = 3'b000;
    rs_val = 32'd7;
    rt_val = 32'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_hi", hi, 32'h0);
    chk("abort_lo", lo, 32'h0);
    chk("abort_busy", busy, 1'b0);
    pulses = 0;
    repeat (50) begin
      if (done) pulses++;
      @(negedge clk);
    end
    chk("abort_no_done", pulses, 0);

    mul_div("mult_after", 3'b000, 32'd7, 32'd9, 32'h00000000, 32'd63, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
